// File: rtl/ring_fifo_ctrl.sv
// ring_fifo_ctrl
//   Synchronous first-word-fall-through FIFO with ready/valid on both sides.
//   Holds up to SIZE entries in a circular store; pointers wrap at SIZE-1,
//   so SIZE need not be a power of two.
//
// Ports
//   i_clk          clock, all state updates on rising edge
//   i_reset        synchronous active-high reset (highest priority)
//   i_clear        synchronous flush of all entries
//   i_push_valid   producer offers i_push_data
//   o_push_ready   FIFO can accept an entry (!o_full)
//   i_push_data    entry to write
//   o_pop_valid    head entry available (!o_empty)
//   i_pop_ready    consumer takes head entry
//   o_pop_data     head entry, combinational read of the head slot
//   o_count        occupancy 0..SIZE
//   o_full         o_count == SIZE
//   o_empty        o_count == 0
module ring_fifo_ctrl #(
   parameter int SIZE  = 32,
   parameter int WIDTH = 64,
   localparam int CW   = $clog2(SIZE + 1),
   localparam int PW   = $clog2(SIZE)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_push_valid,
   output logic             o_push_ready,
   input  logic [WIDTH-1:0] i_push_data,
   output logic             o_pop_valid,
   input  logic             i_pop_ready,
   output logic [WIDTH-1:0] o_pop_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [PW-1:0]    r_wptr;
   logic [PW-1:0]    r_rptr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_mem [SIZE];

   logic             w_push;
   logic             w_pop;
   logic             w_flush;
   logic [PW-1:0]    w_wptr_nxt;
   logic [PW-1:0]    w_rptr_nxt;

   // Flags come from the registered count only, so ready/valid never see
   // a combinational path from any input (and a full FIFO cannot be
   // relieved by a same-cycle pop).
   assign o_full       = (r_cnt == CW'(SIZE));
   assign o_empty      = (r_cnt == '0);
   assign o_push_ready = !o_full;
   assign o_pop_valid  = !o_empty;
   assign o_count      = r_cnt;
   assign o_pop_data   = r_mem[r_rptr];

   assign w_push  = i_push_valid & o_push_ready;
   assign w_pop   = o_pop_valid & i_pop_ready;
   assign w_flush = i_reset | i_clear;

   // Explicit wrap at SIZE-1 instead of relying on natural overflow.
   assign w_wptr_nxt = (r_wptr == PW'(SIZE - 1)) ? '0 : r_wptr + PW'(1);
   assign w_rptr_nxt = (r_rptr == PW'(SIZE - 1)) ? '0 : r_rptr + PW'(1);

   always_ff @(posedge i_clk) begin
      if (w_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= w_wptr_nxt;
         if (w_pop)  r_rptr <= w_rptr_nxt;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage is never reset; a push coinciding with reset/clear is dropped.
   always_ff @(posedge i_clk) begin
      if (w_push && !w_flush) r_mem[r_wptr] <= i_push_data;
   end

`ifdef SIMULATION
   always @(posedge i_clk) begin
      if (!i_reset) begin
         if (int'(r_cnt) > SIZE)
            $fatal(1, "ring_fifo_ctrl: count %0d exceeds SIZE %0d", r_cnt, SIZE);
         if (((int'(r_wptr) - int'(r_rptr) + SIZE) % SIZE) != (int'(r_cnt) % SIZE))
            $fatal(1, "ring_fifo_ctrl: pointer/count mismatch w=%0d r=%0d c=%0d",
                   r_wptr, r_rptr, r_cnt);
      end
   end
`endif

endmodule
